// File: rtl/velo_lcd_capture_if.sv
// Velo LCD pin bundle plus the framebuffer write port driven by the capture front end.
interface velo_lcd_capture_if;
    logic [3:0]  LCD_D;
    logic        LCD_CP;
    logic        LCD_LP;
    logic        LCD_FLM;
    logic        fb_we;
    logic [18:0] fb_write_addr;
    logic        fb_write_data;

    modport master (
        output LCD_D, LCD_CP, LCD_LP, LCD_FLM,
        input  fb_we, fb_write_addr, fb_write_data
    );

    modport slave (
        input  LCD_D, LCD_CP, LCD_LP, LCD_FLM,
        output fb_we, fb_write_addr, fb_write_data
    );
endinterface

// File: rtl/velo_lcd_capture.sv
// Samples the Velo 500 LCD bus, tracks x/y position and serialises each 4-pixel nibble
// into single-pixel framebuffer writes through a two-entry (active + pending) buffer.
module velo_lcd_capture #(
    parameter int FB_H_SIZE = 640,
    parameter int FB_V_SIZE = 240,
    parameter int INVERT    = 1
) (
    input  logic               PixelClk,
    input  logic               nRST,
    velo_lcd_capture_if.slave  bus,
    output logic               frame_done,
    output logic               locked,
    output logic [9:0]         frame_lines,
    output logic               overrun
);
    localparam logic [9:0]  H10 = 10'(FB_H_SIZE);
    localparam logic [9:0]  V10 = 10'(FB_V_SIZE);
    localparam logic [18:0] H19 = 19'(FB_H_SIZE);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    typedef struct packed {
        logic        vld;
        logic [18:0] base;
        logic [3:0]  nib;
    } nib_t;

    logic [3:0]  d_s1_q, d_s2_q;
    logic [2:0]  ctl_s1_q, ctl_s2_q;   // {FLM, LP, CP}
    logic        cp_h_q, lp_h_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [18:0] line_base_q, line_base_d;
    logic [9:0]  line_cnt_q, line_cnt_d, line_cnt_inc;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic        frame_done_q, frame_done_d;
    logic        locked_q, locked_d;
    logic        overrun_q, overrun_d;
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    nib_t        act_q, act_d, pend_q, pend_d, in_nib, emit_rec;
    logic        pend_full_q, pend_full_d;
    logic        fb_we_q, fb_we_d, fb_data_q, fb_data_d;
    logic [18:0] fb_addr_q, fb_addr_d;
    logic        emit_en;
    logic [1:0]  emit_idx;
    logic        cp_fall, lp_rise, flm_s;

    assign cp_fall = cp_h_q & ~ctl_s2_q[0];
    assign lp_rise = ~lp_h_q & ctl_s2_q[1];
    assign flm_s   = ctl_s2_q[2];

    // The nibble always sees the pre-update position, even when LP rises in the same cycle.
    assign in_nib.vld  = (x_q < H10) && (y_q < V10);
    assign in_nib.base = line_base_q + {9'd0, x_q};
    assign in_nib.nib  = d_s2_q ^ {4{INVERT != 0}};

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_base_d   = line_base_q;
        line_cnt_d    = line_cnt_q;
        frame_lines_d = frame_lines_q;
        frame_done_d  = 1'b0;
        locked_d      = locked_q;
        line_cnt_inc  = (line_cnt_q == 10'd1023) ? 10'd1023 : line_cnt_q + 10'd1;
        if (cp_fall) begin
            x_d = (x_q > 10'd1019) ? 10'd1023 : x_q + 10'd4;
        end
        if (lp_rise) begin
            x_d        = 10'd0;
            line_cnt_d = line_cnt_inc;
            if (flm_s) begin
                y_d           = 10'd0;
                line_base_d   = 19'd0;
                frame_done_d  = 1'b1;
                locked_d      = 1'b1;
                frame_lines_d = line_cnt_inc;
                line_cnt_d    = 10'd0;
            end else if (y_q < V10) begin
                y_d         = y_q + 10'd1;
                line_base_d = line_base_q + H19;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        emit_en     = 1'b0;
        emit_rec    = act_q;
        emit_idx    = idx_q;
        case (state_q)
            S_IDLE: begin
                // Idle capture emits pixel 0 straight away so the first strobe lands at E+1.
                if (cp_fall) begin
                    emit_en  = 1'b1;
                    emit_rec = in_nib;
                    emit_idx = 2'd0;
                    act_d    = in_nib;
                    state_d  = S_SHIFT;
                    idx_d    = 2'd1;
                end
            end
            S_SHIFT: begin
                emit_en = 1'b1;
                if (idx_q == 2'd3) begin
                    idx_d = 2'd0;
                    if (pend_full_q) begin
                        act_d       = pend_q;
                        pend_full_d = cp_fall;
                        if (cp_fall) pend_d = in_nib;
                    end else if (cp_fall) begin
                        act_d = in_nib;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (cp_fall) begin
                        if (!pend_full_q) begin
                            pend_d      = in_nib;
                            pend_full_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data only move on a real write, so they hold across gaps and dropped pixels.
    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (emit_en && emit_rec.vld) begin
            fb_we_d   = 1'b1;
            fb_addr_d = emit_rec.base + {17'd0, emit_idx};
            fb_data_d = emit_rec.nib[2'd3 - emit_idx];
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            d_s1_q        <= '0;
            d_s2_q        <= '0;
            ctl_s1_q      <= '0;
            ctl_s2_q      <= '0;
            cp_h_q        <= 1'b0;
            lp_h_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= V10;
            line_base_q   <= '0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            frame_done_q  <= 1'b0;
            locked_q      <= 1'b0;
            overrun_q     <= 1'b0;
            state_q       <= S_IDLE;
            idx_q         <= '0;
            act_q         <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= 1'b0;
        end else begin
            d_s1_q        <= bus.LCD_D;
            d_s2_q        <= d_s1_q;
            ctl_s1_q      <= {bus.LCD_FLM, bus.LCD_LP, bus.LCD_CP};
            ctl_s2_q      <= ctl_s1_q;
            cp_h_q        <= ctl_s2_q[0];
            lp_h_q        <= ctl_s2_q[1];
            x_q           <= x_d;
            y_q           <= y_d;
            line_base_q   <= line_base_d;
            line_cnt_q    <= line_cnt_d;
            frame_lines_q <= frame_lines_d;
            frame_done_q  <= frame_done_d;
            locked_q      <= locked_d;
            overrun_q     <= overrun_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            act_q         <= act_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
        end
    end

    assign bus.fb_we         = fb_we_q;
    assign bus.fb_write_addr = fb_addr_q;
    assign bus.fb_write_data = fb_data_q;
    assign frame_done        = frame_done_q;
    assign locked            = locked_q;
    assign frame_lines       = frame_lines_q;
    assign overrun           = overrun_q;
endmodule
